// File: rtl/f2i_if.sv
// Handshake/result bundle for the float-to-integer converter.
interface f2i_if #(
  parameter int OUT_W = 32
);
  logic             start;
  logic [31:0]      x;
  logic [OUT_W-1:0] z;
  logic [1:0]       overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, x,
    input  z, overflow, busy, done
  );

  modport slave (
    input  start, x,
    output z, overflow, busy, done
  );
endinterface

// File: rtl/f2i_converter.sv
// Multi-cycle IEEE-754 single to signed OUT_W-bit integer converter, one shift bit per cycle.
// Define F2I_ROUND_EN for round-to-nearest-even; otherwise the result truncates toward zero.
module f2i_converter #(
  parameter int OUT_W = 32
) (
  input  logic clk,
  input  logic rst,
  f2i_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    SHIFT  = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [7:0]       E_SAT   = 8'(126 + OUT_W);
  localparam logic [7:0]       E_UNIT  = 8'd150;
  localparam logic [7:0]       E_HALF  = 8'd126;

  state_t           state_q, state_d;
  logic [31:0]      x_q, x_d;
  logic [OUT_W-1:0] mag_q, mag_d;
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic             left_q, left_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             forced_q, forced_d;
  logic [OUT_W-1:0] res_q, res_d;
  logic [1:0]       code_q, code_d;
  logic [OUT_W-1:0] z_q, z_d;
  logic [1:0]       ovf_q, ovf_d;

  logic             sgn;
  logic [7:0]       exp_f;
  logic [22:0]      frac;
  logic [OUT_W-1:0] sat_val;
  logic             round_inc;
  logic [OUT_W-1:0] rounded;

  assign sgn     = x_q[31];
  assign exp_f   = x_q[30:23];
  assign frac    = x_q[22:0];
  assign sat_val = sgn ? NEG_MIN : POS_MAX;

`ifdef F2I_ROUND_EN
  assign round_inc = guard_q & (sticky_q | mag_q[0]);
`else
  assign round_inc = 1'b0;
`endif

  assign rounded = mag_q + {{(OUT_W-1){1'b0}}, round_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      mag_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      left_q   <= 1'b0;
      cnt_q    <= '0;
      forced_q <= 1'b0;
      res_q    <= '0;
      code_q   <= 2'b00;
      z_q      <= '0;
      ovf_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      mag_q    <= mag_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      left_q   <= left_d;
      cnt_q    <= cnt_d;
      forced_q <= forced_d;
      res_q    <= res_d;
      code_q   <= code_d;
      z_q      <= z_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    mag_d    = mag_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    left_d   = left_q;
    cnt_d    = cnt_q;
    forced_d = forced_q;
    res_d    = res_q;
    code_d   = code_q;
    z_d      = z_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.x;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        forced_d = 1'b1;
        cnt_d    = '0;
        left_d   = 1'b0;
        mag_d    = '0;
        res_d    = '0;
        code_d   = 2'b00;
        state_d  = ROUND;
        if (exp_f == 8'hFF) begin
          res_d  = (frac != 23'd0) ? '0 : sat_val;
          code_d = 2'b11;
        end else if (exp_f == 8'h00) begin
          code_d = (frac != 23'd0) ? 2'b10 : 2'b00;
        end else if (exp_f >= E_SAT) begin
          // -2^(OUT_W-1) itself is representable; everything else this large saturates
          if (sgn && exp_f == E_SAT && frac == 23'd0) begin
            res_d  = NEG_MIN;
            code_d = 2'b00;
          end else begin
            res_d  = sat_val;
            code_d = 2'b01;
          end
        end else if (exp_f < E_HALF) begin
          code_d = 2'b10;
        end else begin
          forced_d = 1'b0;
          mag_d    = {{(OUT_W-24){1'b0}}, 1'b1, frac};
          left_d   = (exp_f > E_UNIT);
          cnt_d    = (exp_f > E_UNIT) ? (exp_f - E_UNIT) : (E_UNIT - exp_f);
          state_d  = (exp_f == E_UNIT) ? ROUND : SHIFT;
        end
      end

      SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[OUT_W-2:0], 1'b0};
        end else begin
          // guard holds the bit just shifted out; earlier ones fold into sticky
          mag_d    = {1'b0, mag_q[OUT_W-1:1]};
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        if (forced_q) begin
          z_d   = res_q;
          ovf_d = code_q;
        end else begin
          z_d   = sgn ? (~rounded + {{(OUT_W-1){1'b0}}, 1'b1}) : rounded;
          ovf_d = (rounded == '0) ? 2'b10 : 2'b00;
        end
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.z        = z_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_f2i_converter.sv
// Vector table plus scoreboard bench for f2i_converter (OUT_W=32), with reset/abort corner sequences.
module tb_f2i_converter;

`ifdef F2I_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  localparam int NV = 23;

  typedef struct {
    logic [31:0] x;
    logic [31:0] z;
    logic [1:0]  ovf;
    int          k;
  } vec_t;

  typedef struct {
    logic [31:0] z;
    logic [1:0]  ovf;
    int          cyc;
    logic [31:0] x;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   compared = 0;
  int   failed = 0;
  int   done_count = 0;
  exp_t sb[$];
  exp_t cur;
  vec_t vecs [NV];

  f2i_if #(.OUT_W(32)) bus ();

  f2i_converter #(.OUT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      done_count <= done_count + 1;
      if (sb.size() == 0) begin
        compared++;
        failed++;
        $display("FAIL unexpected_done: got done=1 (z=%h) required no done", bus.z);
      end else begin
        cur = sb.pop_front();
        $display("txn x=%h z=%h ovf=%b cyc=%0d (req z=%h ovf=%b cyc=%0d)",
                 cur.x, bus.z, bus.overflow, cyc, cur.z, cur.ovf, cur.cyc);
        chk("z", 64'(bus.z), 64'(cur.z));
        chk("overflow", 64'(bus.overflow), 64'(cur.ovf));
        chk("latency", 64'(cyc), 64'(cur.cyc));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(bus.busy), 64'(0));
  endtask

  task automatic run_vec(input logic [31:0] xin, input logic [31:0] zr, input logic [1:0] ovr, input int k);
    exp_t e;
    wait_idle();
    bus.start = 1'b1;
    bus.x     = xin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x     = $urandom();
    e.z   = zr;
    e.ovf = ovr;
    e.cyc = cyc + 2 + k;
    e.x   = xin;
    sb.push_back(e);
    chk("accept_busy", 64'(bus.busy), 64'(1));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    int done_before;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x     = 32'h0;

    vecs[0]  = '{32'h3FC00000, RND ? 32'h2 : 32'h1, 2'b00, 23};
    vecs[1]  = '{32'hC0200000, 32'hFFFFFFFE, 2'b00, 22};
    vecs[2]  = '{32'h3E800000, 32'h0, 2'b10, 0};
    vecs[3]  = '{32'hCF000000, 32'h80000000, 2'b00, 0};
    vecs[4]  = '{32'h4F000000, 32'h7FFFFFFF, 2'b01, 0};
    vecs[5]  = '{32'h7FC00000, 32'h0, 2'b11, 0};
    vecs[6]  = '{32'hFF800000, 32'h80000000, 2'b11, 0};
    vecs[7]  = '{32'h00000001, 32'h0, 2'b10, 0};
    vecs[8]  = '{32'h4B7FFFFF, 32'h00FFFFFF, 2'b00, 0};
    vecs[9]  = '{32'h4EFFFFFF, 32'h7FFFFF80, 2'b00, 7};
    vecs[10] = '{32'h00000000, 32'h0, 2'b00, 0};
    vecs[11] = '{32'h80000000, 32'h0, 2'b00, 0};
    vecs[12] = '{32'h7F800000, 32'h7FFFFFFF, 2'b11, 0};
    vecs[13] = '{32'h3F000000, 32'h0, 2'b10, 24};
    vecs[14] = '{32'h3F400000, RND ? 32'h1 : 32'h0, RND ? 2'b00 : 2'b10, 24};
    vecs[15] = '{32'h40600000, RND ? 32'h4 : 32'h3, 2'b00, 22};
    vecs[16] = '{32'hCEFFFFFF, 32'h80000080, 2'b00, 7};
    vecs[17] = '{32'hCF000001, 32'h80000000, 2'b01, 0};
    vecs[18] = '{32'h3F800000, 32'h1, 2'b00, 23};
    vecs[19] = '{32'hBF800000, 32'hFFFFFFFF, 2'b00, 23};
    vecs[20] = '{32'h4B000001, 32'h00800001, 2'b00, 0};
    vecs[21] = '{32'h3FFFFFFF, RND ? 32'h2 : 32'h1, 2'b00, 23};
    vecs[22] = '{32'h4B800000, 32'h01000000, 2'b00, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_z", 64'(bus.z), 64'(0));
    chk("rst_ovf", 64'(bus.overflow), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Table vectors, issued back to back as soon as the block returns to idle
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i].x, vecs[i].z, vecs[i].ovf, vecs[i].k);
    end
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("z_hold", 64'(bus.z), 64'(32'h01000000));

    // start pulsed while busy must be ignored
    done_before = done_count;
    run_vec(32'h3FC00000, RND ? 32'h2 : 32'h1, 2'b00, 23);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 32'h4F000000;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (20) @(posedge clk);
    #1;
    chk("busy_start_ignored", 64'(done_count - done_before), 64'(1));

    // reset in the middle of SHIFT aborts without a done pulse
    wait_idle();
    bus.start = 1'b1;
    bus.x     = 32'hC0200000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    done_before = done_count;
    repeat (5) @(posedge clk);
    #2;
    chk("z_hold_busy", 64'(bus.z), 64'(RND ? 32'h2 : 32'h1));
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_z", 64'(bus.z), 64'(0));
    chk("abort_ovf", 64'(bus.overflow), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_count - done_before), 64'(0));

    // first conversion after reset behaves normally
    run_vec(32'hC0200000, 32'hFFFFFFFE, 2'b00, 22);
    run_vec(32'h4EFFFFFF, 32'h7FFFFF80, 2'b00, 7);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
